mips_lsu: RTL and testbench
===========================

Name: mips_lsu

Overview:
- Load/store unit directly downstream of the single-cycle MIPS core's data-memory port.
- Core-side: accepts one memory request at a time; memory-side: drives the byte-lane data memory.
- Performs sub-word extraction, sign/zero extension and alignment checks for LB/LBU/LH/LHU/LW/SB/SH/SW.
- Memory has a single whole-word write enable, so SB/SH are done as read-modify-write; busy stalls the core's PC while a request is in flight.

Parameters:
- MEM_LATENCY, 1: cycles from stable mem_addr to valid mem_data_out; legal range 1..15.
- XLEN, 32: data width; only 32 is supported.

Ports:
- clk  in  1  clock, all state changes on posedge.
- rst_b  in  1  synchronous reset, active-high (clears state at a posedge where rst_b=1).
- req_valid  in  1  core presents a request this cycle.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word; 11 is treated as word.
- req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for SB/SH.
- busy  out  1  request in flight; the core holds the PC and request inputs.
- resp_valid  out  1  one-cycle pulse: request finished.
- resp_rdata  out  32  extended load result, valid with resp_valid; 0 for stores.
- misaligned  out  1  pulse with resp_valid: request rejected for alignment.
- mem_addr  out  32  word address {req_addr[31:2],2'b00}.
- mem_data_in  out  8x[0:3]  write bytes to memory.
- mem_data_out  in  8x[0:3]  read bytes from memory.
- mem_write_en  out  1  whole-word write, committed at posedge.

Behaviour:
- Byte order is big-endian.
  - Lane k holds byte addr+k.
  - Word = {lane0,lane1,lane2,lane3}.
  - Byte offset o=req_addr[1:0] selects lane o.
  - Half at o selects lanes o,o+1.
- Reset: state IDLE, counter 0.
  - All outputs 0: busy, resp_valid, resp_rdata, misaligned, mem_addr, mem_data_in, mem_write_en.
  - Reset mid-operation aborts the request: no write is issued and no resp_valid is produced.
- States: IDLE, READ, WRITE, DONE. busy=1 in every state except IDLE.
- IDLE: accepts a request at a posedge with req_valid=1. Captures addr, size, signed, wdata and write. Next state:
  - misaligned (half with addr[0]=1, or word with addr[1:0]!=0) -> DONE with misaligned flag set; no memory access.
  - load, or sub-word store -> READ; counter=MEM_LATENCY-1.
  - word store -> WRITE.
- READ: mem_addr held stable.
  - Counter decrements each cycle.
  - When counter=0, mem_data_out is captured at that edge.
  - Load -> DONE; extracted and extended data goes to the result register.
  - Sub-word store -> WRITE; the read word is merged with the new byte/half in the addressed lanes.
- WRITE: mem_write_en=1 for exactly one cycle; mem_data_in holds the final word; next DONE.
- DONE: resp_valid=1 for one cycle.
  - resp_rdata is the load result, or 0 for stores and misaligned requests.
  - misaligned=1 if flagged.
  - Next state IDLE; a new request is accepted at the following edge, never in the DONE cycle.
- Latency, from the acceptance edge to the resp_valid cycle:
  - misaligned: 1 cycle.
  - word store: 2 cycles.
  - load: MEM_LATENCY+1 cycles.
  - sub-word store: MEM_LATENCY+2 cycles.
- Extension: byte is sign-extended from bit 7 and half from bit 15 when req_signed=1, otherwise zero-extended. Words pass through unchanged.
- mem_write_en is never 1 outside WRITE.
- mem_data_in and mem_addr keep their last values when idle.
- req_valid while busy=1 is ignored; the core must hold the request until the cycle after the resp_valid cycle.

Optional Feature:
- Macro: MIPS_LSU_PERF_CNT_EN.
- Defined:
  - Adds outputs load_count[31:0] and store_count[31:0], both cleared by reset.
  - Each increments in the DONE cycle of a non-misaligned load or store respectively, wrapping at 2^32.
  - Adds misalign_count[15:0], which saturates at 16'hFFFF.
- Undefined: none of these ports or registers exist; behaviour is otherwise identical.

Test Plan:
- MEM_LATENCY=1, mem word 0x11223344 at 0x100; LW 0x100 -> resp_valid 2 cycles after accept, resp_rdata=0x11223344, mem_write_en never high.
- Same word; LB signed at 0x102 with lane2=0x83 -> 0xFFFFFF83; LBU -> 0x00000083; LH signed at 0x102 with lanes 0x8000 -> 0xFFFF8000.
- SB 0x101, wdata 0xAB, over 0x11223344:
  - read phase, then a single mem_write_en pulse with 0x11AB3344;
  - resp_valid MEM_LATENCY+2 cycles after accept;
  - a subsequent LW returns 0x11AB3344.
- LW 0x102 and SH 0x103 -> resp_valid and misaligned together 1 cycle after accept; no memory write; resp_rdata=0.
- MEM_LATENCY=4, LW with req_valid held high throughout:
  - busy high for 5 cycles;
  - exactly one response, and a second request is accepted only after DONE.
  - Separately, rst_b=1 asserted during READ of an SB -> IDLE next cycle, no mem_write_en, no resp_valid, all outputs 0.

Source files
------------

// File: rtl/mips_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mips_lsu
//  Purpose  : Load/store unit between the single-cycle MIPS core data port
//             and a big-endian byte-lane data memory that has one whole-word
//             write enable. It performs LB/LBU/LH/LHU/LW/SB/SH/SW, including
//             sub-word extraction, sign/zero extension and alignment
//             checking. SB/SH are done as read-modify-write.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MEM_LATENCY  cycles from a stable mem_addr to valid mem_data_out (1..15)
//    XLEN         data width; only 32 is supported
//  Ports
//    clk, rst_b           clock; synchronous active-high reset
//    req_valid/_write     request strobe and direction (1 = store)
//    req_size/_signed     00 byte, 01 half, 1x word; sign-extend loads
//    req_addr/_wdata      byte address and store data
//    busy                 request in flight (the core stalls its PC)
//    resp_valid           one-cycle completion pulse
//    resp_rdata           extended load data (0 for stores and rejects)
//    misaligned           pulses with resp_valid when a request is rejected
//    mem_addr             word-aligned memory address
//    mem_data_in[0:3]     write lanes (lane k = byte addr+k)
//    mem_data_out[0:3]    read lanes
//    mem_write_en         whole-word write strobe
//  Optional build macro : MIPS_LSU_PERF_CNT_EN
//    Adds load_count, store_count (wrapping) and misalign_count (saturating).
// ============================================================================
module mips_lsu #(
  parameter int MEM_LATENCY = 1,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            misaligned,
  output logic [XLEN-1:0] mem_addr,
  output logic [7:0]      mem_data_in  [0:3],
  input  logic [7:0]      mem_data_out [0:3],
  output logic            mem_write_en
`ifdef MIPS_LSU_PERF_CNT_EN
  ,
  output logic [31:0]     load_count,
  output logic [31:0]     store_count,
  output logic [15:0]     misalign_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        write_q;
  logic [15:0] wdata_q;     // only the low half is ever merged into memory
  logic        busy_q;
  logic        resp_valid_q;
  logic [31:0] rdata_q;
  logic        misaligned_q;
  logic [31:0] mem_addr_q;
  logic [7:0]  mem_data_in_q [0:3];
  logic        we_q;

  logic        mis_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] load_d;
  logic [7:0]  merge_d [0:3];

  // Size 2'b11 behaves as a word, so any size with bit 1 set is a word.
  always_comb begin
    mis_d = ((req_size == 2'b01) && req_addr[0]) ||
            (req_size[1] && (req_addr[1:0] != 2'b00));
  end

  // Load extraction from the lanes currently presented by memory.
  always_comb begin
    byte_d = mem_data_out[off_q];
    half_d = {mem_data_out[{off_q[1], 1'b0}], mem_data_out[{off_q[1], 1'b1}]};
    load_d = {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
    case (size_q)
      2'b00:   load_d = {{24{signed_q & byte_d[7]}}, byte_d};
      2'b01:   load_d = {{16{signed_q & half_d[15]}}, half_d};
      default: load_d = {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
    endcase
  end

  // Read-modify-write merge: big-endian, so a half's MSB lands in the lower lane.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      merge_d[k] = mem_data_out[k];
    end
    if (size_q == 2'b00) begin
      merge_d[off_q] = wdata_q[7:0];
    end else begin
      merge_d[{off_q[1], 1'b0}] = wdata_q[15:8];
      merge_d[{off_q[1], 1'b1}] = wdata_q[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      off_q        <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      mem_addr_q   <= '0;
      we_q         <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        mem_data_in_q[k] <= '0;
      end
    end else begin
      // Pulse outputs default low; states below raise them for one cycle.
      resp_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      we_q         <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            off_q    <= req_addr[1:0];
            size_q   <= req_size;
            signed_q <= req_signed;
            write_q  <= req_write;
            wdata_q  <= req_wdata[15:0];
            busy_q   <= 1'b1;
            if (mis_d) begin
              // Rejected without touching memory.
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              misaligned_q <= 1'b1;
              rdata_q      <= '0;
            end else begin
              mem_addr_q <= {req_addr[31:2], 2'b00};
              if (!req_write || !req_size[1]) begin
                state_q <= S_READ;
                cnt_q   <= CNT_INIT;
              end else begin
                state_q          <= S_WRITE;
                we_q             <= 1'b1;
                mem_data_in_q[0] <= req_wdata[31:24];
                mem_data_in_q[1] <= req_wdata[23:16];
                mem_data_in_q[2] <= req_wdata[15:8];
                mem_data_in_q[3] <= req_wdata[7:0];
              end
            end
          end
        end
        S_READ: begin
          if (cnt_q == '0) begin
            if (write_q) begin
              state_q <= S_WRITE;
              we_q    <= 1'b1;
              for (int k = 0; k < 4; k++) begin
                mem_data_in_q[k] <= merge_d[k];
              end
            end else begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              rdata_q      <= load_d;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_WRITE: begin
          state_q      <= S_DONE;
          resp_valid_q <= 1'b1;
          rdata_q      <= '0;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          rdata_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = rdata_q;
  assign misaligned   = misaligned_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_in  = mem_data_in_q;
  assign mem_write_en = we_q;

`ifdef MIPS_LSU_PERF_CNT_EN
  logic [31:0] load_cnt_q;
  logic [31:0] store_cnt_q;
  logic [15:0] mis_cnt_q;

  // misaligned_q is high in DONE exactly when the request was rejected.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      mis_cnt_q   <= '0;
    end else if (state_q == S_DONE) begin
      if (misaligned_q) begin
        if (mis_cnt_q != 16'hFFFF) begin
          mis_cnt_q <= mis_cnt_q + 16'd1;
        end
      end else if (write_q) begin
        store_cnt_q <= store_cnt_q + 32'd1;
      end else begin
        load_cnt_q <= load_cnt_q + 32'd1;
      end
    end
  end

  assign load_count     = load_cnt_q;
  assign store_count    = store_cnt_q;
  assign misalign_count = mis_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_lsu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mips_lsu
//  Purpose  : Bench for mips_lsu. Two instances (MEM_LATENCY 1 and 4) share
//             the request fields, each with its own memory model whose read
//             data is garbage until the address has been stable long enough.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_lsu;
  localparam int LAT0 = 1;
  localparam int LAT1 = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic [1:0]  req_valid_a;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  busy_a, rv_a, mis_a, we_a;
  logic [31:0] rdata_a [2];
  logic [31:0] maddr_a [2];
  logic [7:0]  mdi0 [0:3];
  logic [7:0]  mdi1 [0:3];
  logic [7:0]  mdo0 [0:3];
  logic [7:0]  mdo1 [0:3];
  logic [31:0] mdi_w [2];
  logic [31:0] mdo_w [2];

  logic [31:0] mem     [2][256];
  logic [31:0] ref_mem [2][256];
  logic        init_en;
  logic        pre_en;
  int          pre_d;
  logic [7:0]  pre_idx;
  logic [31:0] pre_word;
  int          wr_cnt [2];
  logic [31:0] last_wword [2];
  int          age [2];
  logic [31:0] last_addr [2];

  int checks   = 0;
  int failures = 0;

`ifdef MIPS_LSU_PERF_CNT_EN
  logic [31:0] lc0, sc0, lc1, sc1;
  logic [15:0] mc0, mc1;
`endif

  mips_lsu #(.MEM_LATENCY(LAT0), .XLEN(32)) u_dut0 (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid_a[0]), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy_a[0]), .resp_valid(rv_a[0]), .resp_rdata(rdata_a[0]), .misaligned(mis_a[0]),
    .mem_addr(maddr_a[0]), .mem_data_in(mdi0), .mem_data_out(mdo0), .mem_write_en(we_a[0])
`ifdef MIPS_LSU_PERF_CNT_EN
    , .load_count(lc0), .store_count(sc0), .misalign_count(mc0)
`endif
  );

  mips_lsu #(.MEM_LATENCY(LAT1), .XLEN(32)) u_dut1 (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid_a[1]), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy_a[1]), .resp_valid(rv_a[1]), .resp_rdata(rdata_a[1]), .misaligned(mis_a[1]),
    .mem_addr(maddr_a[1]), .mem_data_in(mdi1), .mem_data_out(mdo1), .mem_write_en(we_a[1])
`ifdef MIPS_LSU_PERF_CNT_EN
    , .load_count(lc1), .store_count(sc1), .misalign_count(mc1)
`endif
  );

  assign mdi_w[0] = {mdi0[0], mdi0[1], mdi0[2], mdi0[3]};
  assign mdi_w[1] = {mdi1[0], mdi1[1], mdi1[2], mdi1[3]};
  assign mdo0[0] = mdo_w[0][31:24];
  assign mdo0[1] = mdo_w[0][23:16];
  assign mdo0[2] = mdo_w[0][15:8];
  assign mdo0[3] = mdo_w[0][7:0];
  assign mdo1[0] = mdo_w[1][31:24];
  assign mdo1[1] = mdo_w[1][23:16];
  assign mdo1[2] = mdo_w[1][15:8];
  assign mdo1[3] = mdo_w[1][7:0];

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory writes commit at the clock edge that ends the write-enable cycle.
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 256; i++) begin
        mem[0][i] <= init_word(i);
        mem[1][i] <= init_word(i);
      end
      wr_cnt[0] <= 0;
      wr_cnt[1] <= 0;
    end else begin
      if (pre_en) mem[pre_d][pre_idx] <= pre_word;
      if (we_a[0]) begin
        mem[0][maddr_a[0][9:2]] <= mdi_w[0];
        wr_cnt[0]               <= wr_cnt[0] + 1;
        last_wword[0]           <= mdi_w[0];
      end
      if (we_a[1]) begin
        mem[1][maddr_a[1][9:2]] <= mdi_w[1];
        wr_cnt[1]               <= wr_cnt[1] + 1;
        last_wword[1]           <= mdi_w[1];
      end
    end
  end

  // Read data becomes valid only after the address has been stable MEM_LATENCY cycles.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int na;
      na = (maddr_a[d] !== last_addr[d]) ? 1 : ((age[d] < 100) ? age[d] + 1 : 100);
      age[d]       <= na;
      last_addr[d] <= maddr_a[d];
      mdo_w[d]     <= (na >= ((d == 0) ? LAT0 : LAT1)) ? mem[d][maddr_a[d][9:2]] : 32'hDEAD_BEEF;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic exp_mis(input logic [1:0] sz, input logic [31:0] a);
    return ((sz == 2'b01) && a[0]) || ((sz >= 2'b10) && (a[1:0] != 2'b00));
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sg);
    int o;
    logic [31:0] v;
    o = int'(off);
    if (sz == 2'b00) begin
      v = (w >> (24 - 8 * o)) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (w >> (16 - 8 * o)) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_store(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic [31:0] wd);
    int o;
    o = int'(off);
    if (sz == 2'b00) return (w & ~(32'hFF << (24 - 8 * o))) | ((wd & 32'hFF) << (24 - 8 * o));
    if (sz == 2'b01) return (w & ~(32'hFFFF << (16 - 8 * o))) | ((wd & 32'hFFFF) << (16 - 8 * o));
    return wd;
  endfunction

  // ---------------- drivers ----------------
  task automatic preload(input int d, input logic [31:0] a, input logic [31:0] w);
    @(negedge clk);
    pre_d    = d;
    pre_idx  = a[9:2];
    pre_word = w;
    pre_en   = 1'b1;
    ref_mem[d][a[9:2]] = w;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // One complete transaction; returns what was observed, judged by the caller.
  task automatic do_req(input int d, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic mis, output int lat,
                        output int nwr, output logic busy_ok, output logic pulse_ok);
    int w0;
    @(negedge clk);
    w0         = wr_cnt[d];
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid_a[d] = 1'b1;
    @(posedge clk);
    #1;
    req_valid_a[d] = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (!busy_a[d]) busy_ok = 1'b0;
      if (rv_a[d]) break;
    end
    rd  = rdata_a[d];
    mis = mis_a[d];
    if (!rv_a[d]) lat = -1;
    @(negedge clk);
    pulse_ok = !rv_a[d] && !busy_a[d];
    nwr      = wr_cnt[d] - w0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy_a[d], rv_a[d], mis_a[d], we_a[d]} !== 4'b0) begin
        failures++;
        $display("FAIL reset_ctrl d=%0d got busy/rv/mis/we=%b required 0000",
                 d, {busy_a[d], rv_a[d], mis_a[d], we_a[d]});
      end
      checks++;
      if (rdata_a[d] !== 32'h0 || maddr_a[d] !== 32'h0 || mdi_w[d] !== 32'h0) begin
        failures++;
        $display("FAIL reset_data d=%0d got rdata=%h addr=%h wdata=%h required 0",
                 d, rdata_a[d], maddr_a[d], mdi_w[d]);
      end
    end
  endtask

  task automatic test_directed;
    logic [31:0] rd;
    logic        mis, bok, pok;
    int          lat, nwr;
    preload(0, 32'h100, 32'h1122_3344);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, mis, lat, nwr, bok, pok);
    checks++; if (rd !== 32'h1122_3344) begin failures++; $display("FAIL lw_data got %h required 11223344", rd); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL lw_latency got %0d required 2", lat); end
    checks++; if (nwr !== 0 || mis !== 1'b0 || !bok || !pok) begin failures++;
      $display("FAIL lw_ctrl got writes=%0d mis=%b busy_ok=%b pulse_ok=%b required 0 0 1 1", nwr, mis, bok, pok); end

    preload(0, 32'h100, 32'h1122_8344);
    do_req(0, 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, rd, mis, lat, nwr, bok, pok);
    checks++; if (rd !== 32'hFFFF_FF83) begin failures++; $display("FAIL lb_signed got %h required ffffff83", rd); end
    do_req(0, 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, rd, mis, lat, nwr, bok, pok);
    checks++; if (rd !== 32'h0000_0083) begin failures++; $display("FAIL lbu got %h required 00000083", rd); end
    preload(0, 32'h100, 32'h1122_8000);
    do_req(0, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, rd, mis, lat, nwr, bok, pok);
    checks++; if (rd !== 32'hFFFF_8000) begin failures++; $display("FAIL lh_signed got %h required ffff8000", rd); end

    preload(0, 32'h100, 32'h1122_3344);
    do_req(0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AB, rd, mis, lat, nwr, bok, pok);
    checks++; if (lat !== LAT0 + 2) begin failures++; $display("FAIL sb_latency got %0d required %0d", lat, LAT0 + 2); end
    checks++; if (nwr !== 1 || last_wword[0] !== 32'h11AB_3344) begin failures++;
      $display("FAIL sb_write got writes=%0d word=%h required 1 11ab3344", nwr, last_wword[0]); end
    checks++; if (rd !== 32'h0 || mis !== 1'b0) begin failures++; $display("FAIL sb_resp got rdata=%h mis=%b required 0 0", rd, mis); end
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, mis, lat, nwr, bok, pok);
    checks++; if (rd !== 32'h11AB_3344) begin failures++; $display("FAIL sb_readback got %h required 11ab3344", rd); end
    ref_mem[0][8'h40] = 32'h11AB_3344;

    do_req(0, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, rd, mis, lat, nwr, bok, pok);
    checks++; if (mis !== 1'b1 || lat !== 1 || rd !== 32'h0 || nwr !== 0) begin failures++;
      $display("FAIL lw_misaligned got mis=%b lat=%0d rdata=%h writes=%0d required 1 1 0 0", mis, lat, rd, nwr); end
    do_req(0, 1'b1, 2'b01, 1'b0, 32'h103, 32'hBEEF, rd, mis, lat, nwr, bok, pok);
    checks++; if (mis !== 1'b1 || lat !== 1 || rd !== 32'h0 || nwr !== 0) begin failures++;
      $display("FAIL sh_misaligned got mis=%b lat=%0d rdata=%h writes=%0d required 1 1 0 0", mis, lat, rd, nwr); end
  endtask

  task automatic test_hold_request;
    logic [31:0] word, rd;
    int nbusy, nresp, rlat, c;
    word = $urandom;
    preload(1, 32'h200, word);
    @(negedge clk);
    req_write  = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'h200;
    req_valid_a[1] = 1'b1;
    @(posedge clk);
    nbusy = 0; nresp = 0; rlat = 0; rd = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (busy_a[1]) nbusy++;
      if (rv_a[1]) begin nresp++; rlat = k; rd = rdata_a[1]; end
    end
    checks++; if (nbusy !== LAT1 + 1) begin failures++; $display("FAIL hold_busy got %0d cycles required %0d", nbusy, LAT1 + 1); end
    checks++; if (nresp !== 1 || rlat !== LAT1 + 1 || rd !== word) begin failures++;
      $display("FAIL hold_resp got count=%0d lat=%0d data=%h required 1 %0d %h", nresp, rlat, rd, LAT1 + 1, word); end
    @(negedge clk);
    checks++; if (busy_a[1] !== 1'b1) begin failures++; $display("FAIL hold_reaccept got busy=%b required 1", busy_a[1]); end
    req_valid_a[1] = 1'b0;
    c = 0;
    while (c < 20 && !rv_a[1]) begin @(negedge clk); c++; end
    checks++; if (rv_a[1] !== 1'b1 || rdata_a[1] !== word) begin failures++;
      $display("FAIL hold_second got rv=%b data=%h required 1 %h", rv_a[1], rdata_a[1], word); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int w0, nresp;
    w0 = wr_cnt[1];
    @(negedge clk);
    req_write  = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0000_0021;
    req_wdata  = 32'h0000_0055;
    req_valid_a[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid_a[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    checks++;
    if ({busy_a[1], rv_a[1], mis_a[1], we_a[1]} !== 4'b0 || rdata_a[1] !== 32'h0 ||
        maddr_a[1] !== 32'h0 || mdi_w[1] !== 32'h0) begin
      failures++;
      $display("FAIL midreset_outputs got busy=%b rv=%b mis=%b we=%b rdata=%h addr=%h wdata=%h required all 0",
               busy_a[1], rv_a[1], mis_a[1], we_a[1], rdata_a[1], maddr_a[1], mdi_w[1]);
    end
    nresp = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rv_a[1]) nresp++;
    end
    checks++; if (nresp !== 0 || wr_cnt[1] !== w0) begin failures++;
      $display("FAIL midreset_abort got responses=%0d writes=%0d required 0 0", nresp, wr_cnt[1] - w0); end
  endtask

  task automatic test_random(input int d, input int n);
    logic [31:0] rd, a, wd, exp_rd;
    logic [1:0]  sz;
    logic        w, sg, mis, bok, pok, em;
    int          lat, nwr, elat, enwr, lmem;
    logic [7:0]  idx;
    lmem = (d == 0) ? LAT0 : LAT1;
    for (int i = 0; i < n; i++) begin
      idx = 8'($urandom_range(0, 15));
      a   = {22'h0, idx, 2'($urandom_range(0, 3))};
      sz  = 2'($urandom_range(0, 3));
      w   = 1'($urandom_range(0, 1));
      sg  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      em  = exp_mis(sz, a);
      exp_rd = 32'h0;
      enwr   = 0;
      if (em) elat = 1;
      else if (!w) begin
        elat   = lmem + 1;
        exp_rd = exp_load(ref_mem[d][idx], a[1:0], sz, sg);
      end else begin
        elat = (sz >= 2'b10) ? 2 : lmem + 2;
        enwr = 1;
        ref_mem[d][idx] = exp_store(ref_mem[d][idx], a[1:0], sz, wd);
      end
      do_req(d, w, sz, sg, a, wd, rd, mis, lat, nwr, bok, pok);
      checks++; if (rd !== exp_rd) begin failures++;
        $display("FAIL rand_rdata d=%0d i=%0d addr=%h sz=%0d w=%b got %h required %h", d, i, a, sz, w, rd, exp_rd); end
      checks++; if (mis !== em || lat !== elat) begin failures++;
        $display("FAIL rand_timing d=%0d i=%0d got mis=%b lat=%0d required %b %0d", d, i, mis, lat, em, elat); end
      checks++; if (nwr !== enwr || !bok || !pok) begin failures++;
        $display("FAIL rand_ctrl d=%0d i=%0d got writes=%0d busy_ok=%b pulse_ok=%b required %0d 1 1", d, i, nwr, bok, pok, enwr); end
    end
    // Read every touched word back to confirm memory matches the model.
    for (int j = 0; j < 16; j++) begin
      do_req(d, 1'b0, 2'b10, 1'b0, 32'(j * 4), 32'h0, rd, mis, lat, nwr, bok, pok);
      checks++; if (rd !== ref_mem[d][j]) begin failures++;
        $display("FAIL rand_final d=%0d word=%0d got %h required %h", d, j, rd, ref_mem[d][j]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[0][i] = init_word(i);
      ref_mem[1][i] = init_word(i);
    end
    rst_b       = 1'b1;
    init_en     = 1'b1;
    pre_en      = 1'b0;
    pre_d       = 0;
    pre_idx     = '0;
    pre_word    = '0;
    req_valid_a = 2'b00;
    req_write   = 1'b0;
    req_size    = 2'b00;
    req_signed  = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    repeat (3) @(negedge clk);
    init_en = 1'b0;
    test_reset();
    rst_b = 1'b0;
    test_directed();
    test_hold_request();
    test_reset_mid_op();
    test_random(0, 40);
    test_random(1, 40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
